midi_tx_arbiter: RTL and testbench

Shares the single MIDI UART transmitter (midi_out_ready / midi_send_byte / midi_out_data) among N_REQ byte-stream requesters: sysex dump engine, MIDI-thru forwarder and CPU port.
Arbitration is round-robin and message-atomic. Once a requester is granted, it owns the transmitter until the byte flagged req_last has been sent, so messages are never interleaved.
A watchdog releases a stalled grant.
Sits between the requesters and MIDI_UART inside synth_controller.

---
 rtl/midi_tx_arbiter.sv | 114 +++++++++++
 tb/tb_midi_tx_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_tx_arbiter.sv
// midi_tx_arbiter: round-robin, message-atomic sharing of one MIDI UART transmitter
module midi_tx_arbiter #(
    parameter int N_REQ     = 3,
    parameter int G_WIDTH   = 2,
    parameter int TIMEOUT   = 4096,
    parameter int BUSY_WAIT = 4
) (
    input  logic               reg_clk,
    input  logic               reset_reg_N,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ack,
    input  logic               midi_out_ready,
    output logic               midi_send_byte,
    output logic [7:0]         midi_out_data,
    output logic               grant_valid,
    output logic [G_WIDTH-1:0] grant_id,
    output logic               timeout_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(BUSY_WAIT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_READY} state_t;

    state_t             state, state_d;
    logic [G_WIDTH-1:0] last_grant, last_grant_d, win, cand, grant_id_d;
    logic [TW-1:0]      tmo, tmo_d;
    logic [BW-1:0]      bcnt, bcnt_d;
    logic [N_REQ-1:0]   ack_d;
    logic [7:0]         data_d;
    logic               rel, rel_d, found, accept, abort, drop;
    logic               send_d, gv_d, terr_d;

    // A byte is taken when the owner offers one and the UART can accept it;
    // an owner that stays silent for TIMEOUT cycles loses the grant.
    assign accept = state == SEND && req_valid[grant_id] && midi_out_ready;
    assign abort  = state == SEND && !req_valid[grant_id] && tmo == TW'(TIMEOUT - 1);
    assign drop   = abort || (state == WAIT_READY && midi_out_ready && rel);

    // Round-robin search starting just after the previous owner
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = G_WIDTH'((int'(last_grant) + i) % N_REQ);
            if (!found && req_valid[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) state <= IDLE;
        else              state <= state_d;
    end

    // Next-state logic; WAIT_BUSY is bounded so a UART that never drops ready cannot stall us
    always_comb begin
        state_d = state;
        case (state)
            IDLE:       state_d = found ? SEND : IDLE;
            SEND:       state_d = accept ? WAIT_BUSY : abort ? IDLE : SEND;
            WAIT_BUSY:  state_d = (!midi_out_ready || bcnt == BW'(BUSY_WAIT - 1)) ? WAIT_READY : WAIT_BUSY;
            WAIT_READY: state_d = !midi_out_ready ? WAIT_READY : rel ? IDLE : SEND;
            default:    state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and internal counters
    always_comb begin
        ack_d           = '0;
        ack_d[grant_id] = accept;
        send_d          = accept;
        data_d          = accept ? req_data[8*grant_id +: 8] : midi_out_data;
        rel_d           = accept ? req_last[grant_id] : rel;
        terr_d          = abort;
        gv_d            = state == IDLE ? found : !drop;
        grant_id_d      = state == IDLE ? win : drop ? '0 : grant_id;
        last_grant_d    = drop ? grant_id : last_grant;
        tmo_d           = (state != SEND || accept || abort) ? '0 : req_valid[grant_id] ? tmo : tmo + TW'(1);
        bcnt_d          = state == WAIT_BUSY ? bcnt + BW'(1) : '0;
    end

    // Output and datapath registers
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            req_ack        <= '0;
            midi_send_byte <= 1'b0;
            midi_out_data  <= '0;
            grant_valid    <= 1'b0;
            grant_id       <= '0;
            timeout_err    <= 1'b0;
            last_grant     <= G_WIDTH'(N_REQ - 1);
            rel            <= 1'b0;
            tmo            <= '0;
            bcnt           <= '0;
        end else begin
            req_ack        <= ack_d;
            midi_send_byte <= send_d;
            midi_out_data  <= data_d;
            grant_valid    <= gv_d;
            grant_id       <= grant_id_d;
            timeout_err    <= terr_d;
            last_grant     <= last_grant_d;
            rel            <= rel_d;
            tmo            <= tmo_d;
            bcnt           <= bcnt_d;
        end
    end
endmodule

// File: tb/tb_midi_tx_arbiter.sv
// tb_midi_tx_arbiter: directed and randomized checks of the MIDI transmit arbiter
module tb_midi_tx_arbiter;
    localparam int N   = 3;
    localparam int GW  = 2;
    localparam int TMO = 16;
    localparam int BW  = 4;

    logic           reg_clk = 1'b0;
    logic           reset_reg_N = 1'b0;
    logic [N-1:0]   req_valid, req_last, req_ack;
    logic [8*N-1:0] req_data;
    logic           midi_out_ready, midi_send_byte, grant_valid, timeout_err;
    logic [7:0]     midi_out_data;
    logic [GW-1:0]  grant_id;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [8:0] mem [N][64];
    int head [N];
    int tail [N];
    int ack_cnt [N];
    int terr_cnt, busy, busy_lo, busy_hi, mlg;
    logic prev_send;
    logic [7:0] sq_data [$];
    int         sq_id [$];
    int         sq_cyc [$];
    logic [7:0] ex_data [$];
    int         ex_id [$];

    midi_tx_arbiter #(.N_REQ(N), .G_WIDTH(GW), .TIMEOUT(TMO), .BUSY_WAIT(BW)) dut (
        .reg_clk(reg_clk), .reset_reg_N(reset_reg_N),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ack(req_ack),
        .midi_out_ready(midi_out_ready), .midi_send_byte(midi_send_byte), .midi_out_data(midi_out_data),
        .grant_valid(grant_valid), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 reg_clk = ~reg_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, req_ack, 0);
        chk({tag, "_send"}, midi_send_byte, 0);
        chk({tag, "_data"}, midi_out_data, 0);
        chk({tag, "_gv"}, grant_valid, 0);
        chk({tag, "_gid"}, grant_id, 0);
        chk({tag, "_terr"}, timeout_err, 0);
    endtask

    // Each requester presents the head of its byte list until acknowledged
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = head[i] < tail[i];
            req_data[8*i +: 8] = head[i] < tail[i] ? mem[i][head[i]][7:0] : 8'h00;
            req_last[i]        = head[i] < tail[i] ? mem[i][head[i]][8] : 1'b0;
        end
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic l);
        mem[r][tail[r]] = {l, b};
        tail[r]++;
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (head[i] < tail[i]) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: sample outputs, record strobes, update requesters and the UART model
    task automatic step();
        @(posedge reg_clk);
        #1;
        cyc++;
        chk("ack_vs_strobe", req_ack, midi_send_byte ? (32'd1 << grant_id) : 32'd0);
        chk("strobe_single", midi_send_byte & prev_send, 0);
        prev_send = midi_send_byte;
        if (midi_send_byte) begin
            sq_data.push_back(midi_out_data);
            sq_id.push_back(int'(grant_id));
            sq_cyc.push_back(cyc);
        end
        if (timeout_err) terr_cnt++;
        for (int i = 0; i < N; i++) if (req_ack[i]) begin
            head[i]++;
            ack_cnt[i]++;
        end
        drive();
        if (midi_send_byte) busy = $urandom_range(busy_hi, busy_lo);
        else if (busy > 0) busy--;
        midi_out_ready = busy == 0;
    endtask

    task automatic do_reset();
        reset_reg_N = 1'b0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            ack_cnt[i] = 0;
        end
        drive();
        busy = 0;
        midi_out_ready = 1'b1;
        terr_cnt = 0;
        prev_send = 1'b0;
        sq_data.delete();
        sq_id.delete();
        sq_cyc.delete();
        repeat (2) @(posedge reg_clk);
        #1 reset_reg_N = 1'b1;
        mlg = N - 1;
    endtask

    // Message-level model: whole messages, owners chosen round-robin after the previous owner
    task automatic build_expected();
        int h [N];
        int lg, r;
        bit any;
        ex_data.delete();
        ex_id.delete();
        for (int i = 0; i < N; i++) h[i] = head[i];
        lg = mlg;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int k = 1; k <= N && !any; k++) begin
                r = (lg + k) % N;
                if (h[r] < tail[r]) begin
                    any = 1'b1;
                    lg = r;
                    do begin
                        ex_data.push_back(mem[r][h[r]][7:0]);
                        ex_id.push_back(r);
                        h[r]++;
                    end while (h[r] < tail[r] && !mem[r][h[r]-1][8]);
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((pending() || grant_valid) && n < 3000) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, n < 3000, 1);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_len"}, sq_data.size(), ex_data.size());
        for (int i = 0; i < ex_data.size() && i < sq_data.size(); i++) begin
            chk({tag, "_data"}, sq_data[i], ex_data[i]);
            chk({tag, "_id"}, sq_id[i], ex_id[i]);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!midi_out_ready && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_ready_back"}, midi_out_ready, 1);
    endtask

    initial begin
        int n, t_entry, nm, len;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        midi_out_ready = 1'b1;
        busy = 0;
        busy_lo = 0;
        busy_hi = 0;
        prev_send = 1'b0;
        terr_cnt = 0;
        mlg = N - 1;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            ack_cnt[i] = 0;
        end
        repeat (2) @(posedge reg_clk);
        #1;
        chk_zero("reset");
        reset_reg_N = 1'b1;

        // Sysex F0 43 F7 from requester 0
        busy_lo = 2;
        busy_hi = 2;
        push(0, 8'hF0, 0); push(0, 8'h43, 0); push(0, 8'hF7, 1);
        drive();
        step();
        chk("t1_grant_v", grant_valid, 1);
        chk("t1_grant_id", grant_id, 0);
        chk("t1_no_early", midi_send_byte, 0);
        step();
        chk("t1_first_strobe", midi_send_byte, 1);
        chk("t1_first_data", midi_out_data, 8'hF0);
        n = 0;
        while (sq_data.size() < 3 && n < 200) begin
            step();
            n++;
        end
        chk("t1_three_strobes", sq_data.size(), 3);
        wait_ready("t1");
        chk("t1_hold_grant", grant_valid, 1);
        step();
        chk("t1_release", grant_valid, 0);
        chk("t1_release_id", grant_id, 0);
        chk("t1_data_held", midi_out_data, 8'hF7);
        ex_data = '{8'hF0, 8'h43, 8'hF7};
        ex_id = '{0, 0, 0};
        compare("t1");
        chk("t1_acks", ack_cnt[0], 3);

        // Two requesters with 3-byte messages: no interleaving
        do_reset();
        busy_lo = 1;
        busy_hi = 3;
        push(0, 8'hA0, 0); push(0, 8'hA1, 0); push(0, 8'hA2, 1);
        push(1, 8'hB0, 0); push(1, 8'hB1, 0); push(1, 8'hB2, 1);
        drive();
        build_expected();
        step();
        chk("t2_first_owner", grant_id, 0);
        drain("t2");
        compare("t2");

        // All three continuously valid with single-byte messages
        do_reset();
        busy_lo = 0;
        busy_hi = 2;
        for (int k = 0; k < 3; k++) begin
            push(0, 8'h90, 1); push(1, 8'h80, 1); push(2, 8'hB0, 1);
        end
        drive();
        build_expected();
        drain("t3");
        compare("t3");
        chk("t3_first", sq_data.size() > 0 ? sq_data[0] : 8'h00, 8'h90);

        // Watchdog: requester 2 goes silent mid-message
        do_reset();
        busy_lo = 2;
        busy_hi = 2;
        push(2, 8'h55, 0);
        drive();
        step();
        chk("t4_owner", grant_id, 2);
        step();
        chk("t4_strobe", midi_send_byte, 1);
        push(0, 8'h11, 1);
        drive();
        wait_ready("t4");
        t_entry = cyc + 1;
        n = 0;
        while (!timeout_err && n < 40) begin
            step();
            n++;
        end
        chk("t4_tmo_time", cyc - t_entry, TMO);
        chk("t4_tmo_release", grant_valid, 0);
        step();
        chk("t4_tmo_pulse", timeout_err, 0);
        chk("t4_next_v", grant_valid, 1);
        chk("t4_next_owner", grant_id, 0);
        drain("t4");
        chk("t4_terr_cnt", terr_cnt, 1);

        // Byte arriving on the last watchdog cycle is accepted instead of timing out
        do_reset();
        busy_lo = 2;
        busy_hi = 2;
        push(2, 8'h21, 0);
        drive();
        step();
        step();
        chk("t4b_strobe", midi_send_byte, 1);
        wait_ready("t4b");
        t_entry = cyc + 1;
        while (cyc < t_entry + TMO - 1) step();
        push(2, 8'h22, 1);
        drive();
        step();
        chk("t4b_byte_wins", midi_send_byte, 1);
        chk("t4b_data", midi_out_data, 8'h22);
        chk("t4b_no_tmo", timeout_err, 0);
        drain("t4b");
        chk("t4b_terr", terr_cnt, 0);

        // UART ready never drops
        do_reset();
        busy_lo = 0;
        busy_hi = 0;
        push(1, 8'hC0, 0); push(1, 8'hC1, 0); push(1, 8'hC2, 0); push(1, 8'hC3, 1);
        drive();
        build_expected();
        drain("t5");
        compare("t5");
        chk("t5_acks", ack_cnt[1], 4);
        for (int i = 1; i < sq_cyc.size(); i++) chk("t5_spacing", sq_cyc[i] - sq_cyc[i-1] >= BW, 1);

        // Reset during WAIT_READY drops the message; requester 0 wins afterwards
        do_reset();
        busy_lo = 3;
        busy_hi = 3;
        push(1, 8'hD0, 0); push(1, 8'hD1, 0); push(1, 8'hD2, 1);
        drive();
        step();
        chk("t6_owner", grant_id, 1);
        step();
        chk("t6_strobe", midi_send_byte, 1);
        step();
        #2 reset_reg_N = 1'b0;
        #1 chk_zero("t6_rst");
        push(0, 8'hE0, 1);
        drive();
        busy = 0;
        midi_out_ready = 1'b1;
        prev_send = 1'b0;
        sq_data.delete();
        sq_id.delete();
        sq_cyc.delete();
        repeat (2) @(posedge reg_clk);
        #1 reset_reg_N = 1'b1;
        mlg = N - 1;
        busy_lo = 0;
        busy_hi = 2;
        build_expected();
        step();
        chk("t6_new_v", grant_valid, 1);
        chk("t6_new_owner", grant_id, 0);
        drain("t6");
        compare("t6");

        // Randomized message mixes with a random UART busy time
        for (int it = 0; it < 6; it++) begin
            do_reset();
            busy_lo = 0;
            busy_hi = 4;
            for (int r = 0; r < N; r++) begin
                nm = $urandom_range(3, 0);
                for (int m = 0; m < nm; m++) begin
                    len = $urandom_range(4, 1);
                    for (int b = 0; b < len; b++) push(r, 8'($urandom), b == len - 1);
                end
            end
            drive();
            build_expected();
            drain("rnd");
            compare("rnd");
            chk("rnd_terr", terr_cnt, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
